// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage for a request/response instruction SRAM port.
// The stage keeps at most one request in flight. It buffers the returned
// instruction until decode takes it. Redirects from decode either retarget
// the next fetch or mark the in-flight response to be thrown away.
//
// state | meaning
// ------+-----------------------------------------------------------------
// REQ   | fetch request presented at pc, waiting for the SRAM to accept it
// WAIT  | request accepted, waiting for read data (may be marked discard)
// HOLD  | instruction buffered and offered to decode
module inst_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        aclk,
    input  logic        aresetn,

    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,

    input  logic        br_taken,
    input  logic [31:0] br_target,

    input  logic        ds_allowin,
    output logic        fs_to_ds_valid,
    output logic [31:0] fs_to_ds_pc,
    output logic [31:0] fs_to_ds_inst
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    // Holds the request off for the first cycle after reset, so a request is
    // never presented while reset is asserted.
    logic        req_en_q;

    logic        req_fire;

    assign req_fire = req_en_q && (state_q == S_REQ) && inst_sram_addr_ok;

    // State and datapath registers; reset aborts any transaction in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            tgt_q      <= 32'h0;
            buf_pc_q   <= 32'h0;
            buf_inst_q <= 32'h0;
            req_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            tgt_q      <= tgt_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
            req_en_q   <= 1'b1;
        end
    end

    // Next-state logic: fetch sequencing, redirect capture and discard handling.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        tgt_d      = tgt_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;

        case (state_q)
            S_REQ: begin
                // The address on the bus stays put until accepted; a redirect
                // only dooms the response of this request and records where
                // to go afterwards.
                if (br_taken) begin
                    tgt_d     = br_target;
                    discard_d = 1'b1;
                end
                if (req_fire) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    if (discard_q || br_taken) begin
                        // A same-cycle redirect is newer than any latched one.
                        state_d   = S_REQ;
                        pc_d      = br_taken ? br_target : tgt_q;
                        discard_d = 1'b0;
                    end else begin
                        state_d    = S_HOLD;
                        buf_pc_d   = pc_q;
                        buf_inst_d = inst_sram_rdata;
                    end
                end else if (br_taken) begin
                    discard_d = 1'b1;
                    tgt_d     = br_target;
                end
            end

            S_HOLD: begin
                // A redirect wins over decode consuming the buffered word.
                if (br_taken) begin
                    state_d = S_REQ;
                    pc_d    = br_target;
                end else if (ds_allowin) begin
                    state_d = S_REQ;
                    pc_d    = pc_q + 32'd4;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    assign inst_sram_req   = req_en_q && (state_q == S_REQ);
    assign inst_sram_addr  = pc_q;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_wdata = 32'h0;

    assign fs_to_ds_valid  = (state_q == S_HOLD);
    assign fs_to_ds_pc     = buf_pc_q;
    assign fs_to_ds_inst   = buf_inst_q;

endmodule

// File: doc/inst_fetch_stage.md
INST_FETCH_STAGE -- requirements
Module: inst_fetch_stage

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h1c000000, the first fetch address after reset.
REQ-002 The block SHALL have these ports:
- aclk  in  1  clock; all state changes on the rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- inst_sram_req  out  1  fetch request valid.
- inst_sram_wr  out  1  write flag; constant 0.
- inst_sram_size  out  2  access size; constant 2'b10.
- inst_sram_wstrb  out  4  write strobe; constant 4'b0.
- inst_sram_addr  out  32  fetch address.
- inst_sram_wdata  out  32  write data; constant 0.
- inst_sram_addr_ok  in  1  request accepted this cycle.
- inst_sram_data_ok  in  1  read data returned this cycle.
- inst_sram_rdata  in  32  returned instruction.
- br_taken  in  1  one-cycle redirect pulse from decode.
- br_target  in  32  redirect address; valid when br_taken=1.
- ds_allowin  in  1  decode accepts an instruction this cycle.
- fs_to_ds_valid  out  1  buffered instruction valid.
- fs_to_ds_pc  out  32  PC of the buffered instruction.
- fs_to_ds_inst  out  32  buffered instruction word.

Function
REQ-003 The block SHALL implement a 3-state FSM: REQ (inst_sram_req=1), WAIT (request accepted, awaiting data), HOLD (instruction buffered, fs_to_ds_valid=1).
REQ-004 The block SHALL allow at most one outstanding request.
REQ-005 In REQ, the block SHALL keep inst_sram_req=1 and inst_sram_addr=pc stable until inst_sram_addr_ok=1, regardless of br_taken.
REQ-006 REQ->WAIT SHALL occur on the cycle inst_sram_addr_ok=1.
REQ-007 WAIT->HOLD SHALL occur on inst_sram_data_ok=1 when no discard is pending. The buffer SHALL capture inst_sram_rdata and pc, and fs_to_ds_valid SHALL assert on the next cycle.
REQ-008 HOLD->REQ SHALL occur when ds_allowin=1, with pc<=pc+4, wrapping modulo 2^32 (32'hfffffffc -> 32'h0).
REQ-009 In HOLD with ds_allowin=0, the block SHALL hold fs_to_ds_valid, fs_to_ds_pc and fs_to_ds_inst stable.
REQ-010 br_taken in REQ without addr_ok SHALL:
- latch br_target into a pending-redirect register;
- set the discard flag at acceptance.
REQ-011 br_taken in REQ with addr_ok in the same cycle SHALL go to WAIT with discard set and the target latched.
REQ-012 br_taken in WAIT without data_ok SHALL set discard and latch the target.
REQ-013 On data_ok in WAIT with discard set, or with br_taken in the same cycle, the block SHALL:
- drop the data;
- clear discard;
- go to REQ with pc<=latched (or current) target.
REQ-014 br_taken in HOLD SHALL:
- clear fs_to_ds_valid the next cycle;
- go to REQ with pc<=br_target.
It SHALL take priority over ds_allowin.
REQ-015 A later br_taken SHALL overwrite an earlier pending target; only the most recent target is fetched.
REQ-016 The block SHALL ignore inst_sram_data_ok outside WAIT and inst_sram_addr_ok outside REQ.
REQ-017 Minimum fetch-to-valid latency SHALL be 2 cycles: addr_ok in cycle N, data_ok in N+1, fs_to_ds_valid=1 in N+2.

Reset
REQ-018 While aresetn=0, outputs SHALL be:
- state=REQ, pc=RESET_PC;
- inst_sram_req=0;
- fs_to_ds_valid=0, fs_to_ds_pc=0, fs_to_ds_inst=0;
- discard=0, pending target=0.
REQ-019 inst_sram_req SHALL first assert in the first clock after aresetn deasserts, with inst_sram_addr=RESET_PC.
REQ-020 Reset asserted mid-transaction SHALL abort all state immediately. A data_ok arriving after reset release, before any new addr_ok, SHALL be ignored.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset release; addr_ok=1 immediately; data_ok next cycle with rdata=32'h02800401 -> fs_to_ds_valid=1, pc=32'h1c000000, inst=32'h02800401; with ds_allowin=1, next addr=32'h1c000004.
- ds_allowin=0 for 5 cycles in HOLD -> outputs stable and inst_sram_req=0 throughout; ds_allowin=1 -> REQ with pc+4.
- br_taken (target 32'h1c000100) in REQ with addr_ok held low 3 cycles -> addr stays at old pc until accepted; returned data dropped; next request addr=32'h1c000100.
- br_taken coincident with data_ok in WAIT -> no fs_to_ds_valid pulse; next request addr=target.
- br_taken in HOLD with ds_allowin=1 same cycle -> buffered instruction dropped; next addr=target, not pc+4.
- pc=32'hfffffffc accepted by decode -> next addr=32'h00000000; aresetn pulsed low in WAIT -> req=0, valid=0 at once; the stale data_ok is ignored.
